sonar_ranging_scheduler: RTL and testbench

//  Sequences up to N_SENSORS HC-SR04 ultrasonic rangers that share one acoustic space.

---
 rtl/sonar_ranging_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_sonar_ranging_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sonar_ranging_scheduler.sv
// Round-robin HC-SR04 ranging scheduler: fires one sensor per slot, measures the
// echo width in microseconds with rise/width timeouts, and posts one tagged result per slot.

module sonar_echo_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];
endmodule

module sonar_ranging_scheduler #(
    parameter int N_SENSORS    = 4,
    parameter int TICKS_PER_US = 40,
    parameter int TRIG_US      = 20,
    parameter int SLOT_US      = 60000,
    parameter int RISE_US      = 1000,
    parameter int MAX_US       = 4000,
    localparam int SW          = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable_i,
    input  logic [N_SENSORS-1:0] echo_i,
    output logic [N_SENSORS-1:0] trig_o,
    output logic [11:0]          result_o,
    output logic [SW-1:0]        result_id_o,
    output logic                 result_timeout_o,
    output logic                 result_valid_o,
    output logic                 busy_o
);
    localparam int PW  = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam int SLW = $clog2(SLOT_US + 1);
    localparam int CW  = 12;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TRIG    = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_MEASURE = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    typedef struct packed {
        logic [CW-1:0] width;
        logic [SW-1:0] id;
        logic          timeout;
    } res_t;

    logic [N_SENSORS-1:0] echo_s;
    logic [2:0]           state_q, state_d;
    logic [SW-1:0]        idx_q, idx_d;
    logic [PW-1:0]        pre_q, pre_d;
    logic [SLW-1:0]       slot_q, slot_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    res_t                 res_q, res_d;
    logic                 valid_q, valid_d;
    logic [N_SENSORS-1:0] trig_q, trig_d;
    logic                 busy_q, busy_d;
    logic                 tick;
    logic                 echo_sel;
    logic [SW-1:0]        idx_next;

    for (genvar i = 0; i < N_SENSORS; i++) begin : g_sync
        sonar_echo_sync u_sync (
            .clk   (clk),
            .reset (reset),
            .d_i   (echo_i[i]),
            .q_o   (echo_s[i])
        );
    end

    assign tick     = (pre_q == PW'(TICKS_PER_US - 1));
    assign echo_sel = echo_s[idx_q];
    assign idx_next = (idx_q == SW'(N_SENSORS - 1)) ? '0 : idx_q + SW'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pre_d   = tick ? '0 : pre_q + PW'(1);
        slot_d  = (tick && state_q != S_IDLE) ? slot_q + SLW'(1) : slot_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    state_d = S_TRIG;
                    pre_d   = '0;
                    slot_d  = '0;
                end
            end
            S_TRIG: begin
                if (!enable_i) begin
                    state_d = S_IDLE;
                end else if (tick && slot_q == SLW'(TRIG_US - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (!enable_i) begin
                    state_d = S_IDLE;
                end else if (echo_sel) begin
                    state_d = S_MEASURE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CW'(RISE_US - 1)) begin
                        state_d = S_HOLDOFF;
                        res_d   = '{width: CW'(MAX_US), id: idx_q, timeout: 1'b1};
                        valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_MEASURE: begin
                if (!enable_i) begin
                    state_d = S_IDLE;
                end else if (!echo_sel) begin
                    state_d = S_HOLDOFF;
                    res_d   = '{width: cnt_q, id: idx_q, timeout: 1'b0};
                    valid_d = 1'b1;
                end else if (tick) begin
                    // Saturate on the tick that would make the width MAX_US; no wrap possible.
                    if (cnt_q == CW'(MAX_US - 1)) begin
                        state_d = S_HOLDOFF;
                        res_d   = '{width: CW'(MAX_US), id: idx_q, timeout: 1'b1};
                        valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_HOLDOFF: begin
                if (tick && slot_q == SLW'(SLOT_US - 1)) begin
                    idx_d = idx_next;
                    if (enable_i) begin
                        state_d = S_TRIG;
                        slot_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Trigger pins are registered off the next state so they never glitch.
        for (int i = 0; i < N_SENSORS; i++) begin
            trig_d[i] = (state_d == S_TRIG) && (idx_d == SW'(i));
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            pre_q   <= '0;
            slot_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            trig_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            trig_q  <= trig_d;
            busy_q  <= busy_d;
        end
    end

    assign trig_o           = trig_q;
    assign result_o         = res_q.width;
    assign result_id_o      = res_q.id;
    assign result_timeout_o = res_q.timeout;
    assign result_valid_o   = valid_q;
    assign busy_o           = busy_q;
endmodule

// File: tb/tb_sonar_ranging_scheduler.sv
// Scoreboard bench for sonar_ranging_scheduler with scaled-down timing parameters.

module tb_sonar_ranging_scheduler;
    localparam int N    = 4;
    localparam int T    = 2;
    localparam int TRIG = 3;
    localparam int SLOT = 200;
    localparam int RISE = 20;
    localparam int MAXU = 100;
    // trig rise -> result_valid for a no-echo slot: (TRIG + RISE) us of ticks
    localparam int LAT_TO = (TRIG + RISE) * T;

    typedef struct {
        int id;
        int res;
        bit to;
        int tol;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [N-1:0] echo = '0;
    logic [N-1:0] stuck = '0;
    logic [N-1:0] trig;
    logic [11:0]  result;
    logic [1:0]   result_id;
    logic         result_timeout;
    logic         result_valid;
    logic         busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t0_q = 0;
    exp_t q[$];

    sonar_ranging_scheduler #(
        .N_SENSORS(N), .TICKS_PER_US(T), .TRIG_US(TRIG),
        .SLOT_US(SLOT), .RISE_US(RISE), .MAX_US(MAXU)
    ) dut (
        .clk(clk), .reset(reset), .enable_i(enable), .echo_i(echo),
        .trig_o(trig), .result_o(result), .result_id_o(result_id),
        .result_timeout_o(result_timeout), .result_valid_o(result_valid),
        .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic push(input int id, input int res, input bit to, input int tol);
        exp_t e;
        e.id = id; e.res = res; e.to = to; e.tol = tol;
        q.push_back(e);
    endtask

    task automatic wait_rise(input int exp_idx, input bit chk_sp);
        int n = 0;
        logic [N-1:0] one = 1;
        while (trig == '0 && n < 2000) begin @(negedge clk); n++; end
        chk(trig == (one << exp_idx), "trig_idx", int'(trig), int'(one << exp_idx));
        if (chk_sp) chk(cyc - t0_q == SLOT * T, "trig_spacing", cyc - t0_q, SLOT * T);
        t0_q = cyc;
    endtask

    task automatic wait_fall();
        int n = 0;
        while (trig != '0 && n < 1000) begin @(negedge clk); n++; end
        chk(n == TRIG * T, "trig_width", n, TRIG * T);
    endtask

    task automatic wait_valid_lat(input int lat);
        int n = 0;
        while (!result_valid && n < 1000) begin @(negedge clk); n++; end
        chk(result_valid && (cyc - t0_q == lat), "valid_latency", cyc - t0_q, lat);
    endtask

    // Echo pulse on sensor idx (dly/wid in us after trig fall), random noise on masked pins.
    task automatic drive_slot(input int idx, input int dly, input int wid, input logic [N-1:0] noise);
        logic [N-1:0] e;
        for (int c = 0; c < (dly + wid + 5) * T; c++) begin
            e = stuck;
            if (wid > 0 && c >= dly * T && c < (dly + wid) * T) e[idx] = 1'b1;
            e = e | (noise & N'($urandom));
            echo = e;
            @(negedge clk);
        end
        echo = stuck;
    endtask

    initial begin
        int nv;
        fork
            forever begin : monitor
                exp_t e;
                @(negedge clk);
                if (result_valid) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid actual id=%0d res=%0d to=%0d required none",
                                 result_id, result, result_timeout);
                    end else begin
                        e = q.pop_front();
                        if (int'(result_id) != e.id || result_timeout != e.to ||
                            int'(result) > e.res + e.tol || int'(result) < e.res - e.tol) begin
                            errors++;
                            $display("FAIL result actual id=%0d res=%0d to=%0d required id=%0d res=%0d+/-%0d to=%0d",
                                     result_id, result, result_timeout, e.id, e.res, e.tol, e.to);
                        end
                    end
                end
                if (trig != '0) begin
                    checks++;
                    if (!$onehot(trig)) begin
                        errors++;
                        $display("FAIL trig_onehot actual=%b required one-hot", trig);
                    end
                end
            end
        join_none

        // reset state
        repeat (3) @(negedge clk);
        chk(trig == '0 && !busy && !result_valid, "reset_ctrl", int'({trig, busy, result_valid}), 0);
        chk(result == '0 && result_id == '0 && !result_timeout, "reset_result", int'(result), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk(trig == '0 && !busy, "idle_disabled", int'({trig, busy}), 0);

        // 1: sensor 0, echo 50 us starting 5 us after trig fall
        enable = 1'b1;
        wait_rise(0, 0);
        push(0, 50, 0, 1);
        wait_fall();
        drive_slot(0, 5, 50, '0);

        // 2: no echo -> timeouts 23 us into each slot, ids 1,2,3,0
        for (int s = 1; s <= 4; s++) begin
            wait_rise(s % N, 1);
            push(s % N, MAXU, 1, 0);
            wait_fall();
            wait_valid_lat(LAT_TO);
        end

        // 3: echo[2] stuck high; neighbours unaffected
        stuck = 4'b0100;
        echo = stuck;
        wait_rise(1, 1); push(1, MAXU, 1, 0); wait_fall();
        wait_rise(2, 1); push(2, MAXU, 1, 0); wait_fall();
        wait_rise(3, 1); push(3, 30, 0, 1); wait_fall(); drive_slot(3, 2, 30, '0);
        wait_rise(0, 1); push(0, 10, 0, 1); wait_fall(); drive_slot(0, 10, 10, '0);
        stuck = '0;
        echo = '0;

        // 4: sensor 1 width 62 us while pins 0 and 3 toggle randomly
        wait_rise(1, 1); push(1, 62, 0, 1); wait_fall(); drive_slot(1, 4, 62, 4'b1001);

        // 5: abort in MEASURE on sensor 3, then re-enable restarts sensor 3
        wait_rise(2, 1); push(2, MAXU, 1, 0); wait_fall();
        wait_rise(3, 1); wait_fall();
        repeat (4) @(negedge clk);
        echo[3] = 1'b1;
        repeat (40) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk(trig == '0 && !busy, "abort_idle", int'({trig, busy}), 0);
        nv = 0;
        repeat (200) @(negedge clk) if (result_valid) nv++;
        chk(nv == 0, "abort_no_valid", nv, 0);
        echo = '0;
        enable = 1'b1;
        wait_rise(3, 0); push(3, MAXU, 1, 0); wait_fall(); wait_valid_lat(LAT_TO);

        // 6: reset during TRIG of sensor 2; afterwards schedule restarts at sensor 0
        wait_rise(0, 1); push(0, MAXU, 1, 0); wait_fall(); wait_valid_lat(LAT_TO);
        wait_rise(1, 1); push(1, MAXU, 1, 0); wait_fall(); wait_valid_lat(LAT_TO);
        wait_rise(2, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk(trig == '0 && !busy, "reset_mid_trig", int'({trig, busy}), 0);
        chk(result == '0 && !result_timeout, "reset_mid_result", int'(result), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk(q.size() == 0, "pending_at_reset", q.size(), 0);
        wait_rise(0, 0); push(0, MAXU, 1, 0); wait_fall(); wait_valid_lat(LAT_TO);

        nv = 0;
        while (q.size() != 0 && nv < 1000) begin @(negedge clk); nv++; end
        chk(q.size() == 0, "scoreboard_drained", q.size(), 0);
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
